demux32_1to2: RTL and testbench
===============================

DEMUX32_1TO2 -- requirements
Module: demux32_1to2

Interface
REQ-001 Parameter DEPTH, default 2, per-output buffer depth in words; SHALL be a power of two, at least 2.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  32  input word.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_sel  input  1  destination when alt_mode=0 (0 -> out0, 1 -> out1).
REQ-009 alt_mode  input  1  1 = ping-pong routing by internal pointer; in_sel ignored.
REQ-010 out0_data / out1_data  output  32  head word of channel buffer.
REQ-011 out0_valid / out1_valid  output  1  channel buffer non-empty.
REQ-012 out0_ready / out1_ready  input  1  downstream consumes head word.
REQ-013 cnt0 / cnt1  output  16  words accepted into each channel since reset.
REQ-014 next_sel  output  1  current ping-pong pointer value.

Function
REQ-015 Target channel SHALL be next_sel when alt_mode=1, else in_sel.
REQ-016 in_ready SHALL equal NOT full(target); it SHALL NOT depend on in_valid or on the target channel's out_ready (no pop-bypass when full).
REQ-017 Transfer SHALL occur when in_valid=1 and in_ready=1; the word SHALL be written to the target buffer at that rising edge.
REQ-018 Each channel SHALL be a DEPTH-entry FIFO; per-channel word order SHALL be preserved.
REQ-019 outN_valid SHALL be 1 exactly when channel N holds at least one word; outN_data SHALL be the oldest word, and 32'h0 when outN_valid=0.
REQ-020 Pop SHALL occur on channel N when outN_valid=1 and outN_ready=1; outN_ready with empty buffer SHALL have no effect.
REQ-021 Latency SHALL be one cycle: a word accepted at edge k into an empty channel is visible on outN at edge k; there SHALL be no combinational path from in_data/in_valid to any outN signal.
REQ-022 Push and pop on the same non-full channel in one cycle SHALL both occur; occupancy unchanged.
REQ-023 A push to one channel and a pop from the other SHALL proceed independently in the same cycle.
REQ-024 cntN SHALL increment by 1 on each transfer into channel N and SHALL wrap 16'hFFFF -> 16'h0000.
REQ-025 next_sel SHALL toggle only on a transfer while alt_mode=1; it SHALL hold while alt_mode=0 or no transfer occurs.
REQ-026 Changing alt_mode or in_sel SHALL take effect in the same cycle (in_ready recomputed combinationally); buffered words are unaffected.
REQ-027 FIFO read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished with an extra pointer bit or occupancy counter.

Reset
REQ-028 While rst=1 at a rising edge, both buffers SHALL be emptied, cnt0=cnt1=0, next_sel=0; rst SHALL dominate any simultaneous transfer or pop.
REQ-029 In the cycle following reset: out0_valid=out1_valid=0, out0_data=out1_data=0, in_ready=1 for either target.
REQ-030 Reset asserted mid-stream SHALL discard all buffered words; no stale word SHALL appear after reset.

Verification
REQ-031 After reset, alt_mode=0, in_sel=1, push 32'hA5A5_0001 with outs ready=0 -> next cycle out1_valid=1, out1_data=32'hA5A5_0001, out0_valid=0, cnt1=1.
REQ-032 DEPTH=2, in_sel=0, outs ready=0, push 3 words -> first two accepted, in_ready=0 for target 0 on third, cnt0=2; in_sel=1 -> in_ready=1 immediately.
REQ-033 alt_mode=1, in_valid held, push 4 words 1,2,3,4 with both outs ready=1 -> out0 delivers 1,3, out1 delivers 2,4; next_sel ends 0; cnt0=cnt1=2.
REQ-034 Channel 0 holding 1 word, same-cycle push to 0 and pop from 0 -> occupancy stays 1, head becomes the pushed word one cycle later in order.
REQ-035 Force cnt0 to 16'hFFFF via 65535 transfers, one more transfer -> cnt0=16'h0000.
REQ-036 Fill both channels, assert rst for one cycle concurrent with in_valid=1 and out ready=1 -> next cycle both valid=0, cnt0=cnt1=0, next_sel=0.

Source files
------------

// File: rtl/demux32_1to2.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty; head word is 0 when empty.
// Latency: a pushed word is at the head right after the write edge when the FIFO was empty.
// Backpressure: push is ignored when full and pop is ignored when empty; the caller gates on full.
module demux32_1to2_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push   = push && !full;
    assign do_pop    = pop && not_empty;
    assign head_data = not_empty ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end
endmodule

// 1-to-2 word demux into per-channel FIFOs, routed by in_sel or an alternating pointer.
// Latency: one cycle; an accepted word reaches an empty channel's output right after the accept edge.
// Backpressure: in_ready is low while the selected channel is full; no same-cycle pop bypass.
module demux32_1to2 #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sel,
    input  logic        alt_mode,
    output logic [31:0] out0_data,
    output logic        out0_valid,
    input  logic        out0_ready,
    output logic [31:0] out1_data,
    output logic        out1_valid,
    input  logic        out1_ready,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1,
    output logic        next_sel
);
    localparam logic [15:0] CNT_ONE = 16'd1;

    logic target;
    logic full0;
    logic full1;
    logic xfer_vld;
    logic push0;
    logic push1;

    assign target   = alt_mode ? next_sel : in_sel;
    assign in_ready = target ? !full1 : !full0;
    assign xfer_vld = in_valid && in_ready;
    assign push0    = xfer_vld && !target;
    assign push1    = xfer_vld && target;

    demux32_1to2_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .head_data (out0_data),
        .not_empty (out0_valid),
        .full      (full0)
    );

    demux32_1to2_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .head_data (out1_data),
        .not_empty (out1_valid),
        .full      (full1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0     <= '0;
            cnt1     <= '0;
            next_sel <= 1'b0;
        end else begin
            if (push0) begin
                cnt0 <= cnt0 + CNT_ONE;
            end
            if (push1) begin
                cnt1 <= cnt1 + CNT_ONE;
            end
            // The ping-pong pointer only advances when it actually routed a word.
            if (xfer_vld && alt_mode) begin
                next_sel <= !next_sel;
            end
        end
    end
endmodule

// File: tb/tb_demux32_1to2.sv
// Directed bench for demux32_1to2 (DEPTH=2); inputs change and outputs are sampled on the falling edge.
module tb_demux32_1to2;
    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic        alt_mode;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic        next_sel;

    int tests_run;
    int tests_failed;

    demux32_1to2 #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .alt_mode   (alt_mode),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .next_sel   (next_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        in_data    = '0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        alt_mode   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        in_sel = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready0: got %b want 1", in_ready); end
        in_sel = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready1: got %b want 1", in_ready); end
        tests_run++;
        if ({out0_valid, out1_valid} !== 2'b00) begin tests_failed++; $display("FAIL reset_valid: got %b want 00", {out0_valid, out1_valid}); end
        tests_run++;
        if (out0_data !== 32'h0 || out1_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h %h want 0 0", out0_data, out1_data); end
        tests_run++;
        if (cnt0 !== 16'h0 || cnt1 !== 16'h0 || next_sel !== 1'b0) begin tests_failed++; $display("FAIL reset_cnt: got %h %h %b want 0 0 0", cnt0, cnt1, next_sel); end
    endtask

    task automatic test_single();
        do_reset();
        in_sel   = 1'b1;
        in_data  = 32'hA5A5_0001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL single_out1: got %b %h want 1 a5a50001", out1_valid, out1_data); end
        tests_run++;
        if (out0_valid !== 1'b0) begin tests_failed++; $display("FAIL single_out0_valid: got %b want 0", out0_valid); end
        tests_run++;
        if (cnt1 !== 16'd1 || cnt0 !== 16'd0) begin tests_failed++; $display("FAIL single_cnt: got %0d %0d want 0 1", cnt0, cnt1); end
    endtask

    task automatic test_full();
        do_reset();
        in_sel   = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h10;
        @(negedge clk);
        in_data  = 32'h11;
        @(negedge clk);
        in_data  = 32'h12;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        tests_run++;
        if (cnt0 !== 16'd2) begin tests_failed++; $display("FAIL full_cnt0: got %0d want 2", cnt0); end
        tests_run++;
        if (out0_data !== 32'h10) begin tests_failed++; $display("FAIL full_head: got %h want 10", out0_data); end
        in_sel = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_switch_sel: got %b want 1", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_pingpong();
        logic [31:0] got0 [4];
        logic [31:0] got1 [4];
        int n0;
        int n1;
        int acc;
        n0  = 0;
        n1  = 0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            got0[i] = '0;
            got1[i] = '0;
        end
        do_reset();
        alt_mode   = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (out0_valid && out0_ready) begin
                if (n0 < 4) got0[n0] = out0_data;
                n0++;
            end
            if (out1_valid && out1_ready) begin
                if (n1 < 4) got1[n1] = out1_data;
                n1++;
            end
            if (k < 4) begin
                in_valid = 1'b1;
                in_data  = 32'(k + 1);
                #1;
                if (in_ready) acc++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        tests_run++;
        if (acc !== 4) begin tests_failed++; $display("FAIL pp_accepts: got %0d want 4", acc); end
        tests_run++;
        if (n0 !== 2 || got0[0] !== 32'd1 || got0[1] !== 32'd3) begin tests_failed++; $display("FAIL pp_out0: got n=%0d %0d,%0d want n=2 1,3", n0, got0[0], got0[1]); end
        tests_run++;
        if (n1 !== 2 || got1[0] !== 32'd2 || got1[1] !== 32'd4) begin tests_failed++; $display("FAIL pp_out1: got n=%0d %0d,%0d want n=2 2,4", n1, got1[0], got1[1]); end
        tests_run++;
        if (next_sel !== 1'b0) begin tests_failed++; $display("FAIL pp_next_sel: got %b want 0", next_sel); end
        tests_run++;
        if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin tests_failed++; $display("FAIL pp_cnt: got %0d %0d want 2 2", cnt0, cnt1); end
    endtask

    task automatic test_push_pop();
        do_reset();
        in_sel   = 1'b0;
        in_data  = 32'h11;
        in_valid = 1'b1;
        @(negedge clk);
        in_data    = 32'h22;
        out0_ready = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        #1;
        tests_run++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h22) begin tests_failed++; $display("FAIL pushpop_head: got %b %h want 1 22", out0_valid, out0_data); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL pushpop_occupancy: got in_ready %b want 1", in_ready); end
        out0_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out0_valid !== 1'b0 || out0_data !== 32'h0) begin tests_failed++; $display("FAIL pushpop_drain: got %b %h want 0 0", out0_valid, out0_data); end
        @(negedge clk);
        out0_ready = 1'b0;
        in_data    = 32'h33;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h33) begin tests_failed++; $display("FAIL pop_empty_noeffect: got %b %h want 1 33", out0_valid, out0_data); end
    endtask

    task automatic test_independent();
        do_reset();
        in_sel   = 1'b1;
        in_data  = 32'h44;
        in_valid = 1'b1;
        @(negedge clk);
        in_sel     = 1'b0;
        in_data    = 32'h55;
        out1_ready = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        tests_run++;
        if (out1_valid !== 1'b0 || out0_valid !== 1'b1 || out0_data !== 32'h55) begin tests_failed++; $display("FAIL indep: got v1=%b v0=%b d0=%h want 0 1 55", out1_valid, out0_valid, out0_data); end
        tests_run++;
        if (cnt0 !== 16'd1 || cnt1 !== 16'd1) begin tests_failed++; $display("FAIL indep_cnt: got %0d %0d want 1 1", cnt0, cnt1); end
    endtask

    task automatic test_wrap();
        do_reset();
        in_sel     = 1'b0;
        out0_ready = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (cnt0 !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_cnt_max: got %h want ffff", cnt0); end
        tests_run++;
        if (out0_valid !== 1'b1 || out0_data !== 32'd65534) begin tests_failed++; $display("FAIL wrap_stream_head: got %b %h want 1 0000fffe", out0_valid, out0_data); end
        in_data  = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        tests_run++;
        if (cnt0 !== 16'h0000 || cnt1 !== 16'h0000) begin tests_failed++; $display("FAIL wrap_cnt_zero: got %h %h want 0000 0000", cnt0, cnt1); end
        tests_run++;
        if (out0_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wrap_last_head: got %h want deadbeef", out0_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alt_mode = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h101;
        @(negedge clk);
        in_data  = 32'h102;
        @(negedge clk);
        in_data  = 32'h103;
        @(negedge clk);
        alt_mode = 1'b0;
        in_sel   = 1'b1;
        in_data  = 32'h104;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (next_sel !== 1'b1) begin tests_failed++; $display("FAIL mid_next_sel_hold: got %b want 1", next_sel); end
        tests_run++;
        if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin tests_failed++; $display("FAIL mid_fill_cnt: got %0d %0d want 2 2", cnt0, cnt1); end
        in_sel = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_full0: got %b want 0", in_ready); end
        in_sel = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_full1: got %b want 0", in_ready); end
        alt_mode   = 1'b1;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'h999;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        alt_mode   = 1'b0;
        in_sel     = 1'b0;
        #1;
        tests_run++;
        if ({out0_valid, out1_valid} !== 2'b00 || out0_data !== 32'h0 || out1_data !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_outputs: got %b %h %h want 00 0 0", {out0_valid, out1_valid}, out0_data, out1_data); end
        tests_run++;
        if (cnt0 !== 16'h0 || cnt1 !== 16'h0 || next_sel !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_state: got %h %h %b want 0 0 0", cnt0, cnt1, next_sel); end
        in_data  = 32'h777;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (out0_data !== 32'h777 || out1_valid !== 1'b0 || cnt0 !== 16'd1) begin tests_failed++; $display("FAIL mid_no_stale: got %h v1=%b cnt0=%0d want 777 0 1", out0_data, out1_valid, cnt0); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_full();
        test_pingpong();
        test_push_pop();
        test_independent();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
